mult_seq_32_bit: RTL and testbench
==================================

MULT_SEQ_32_BIT -- requirements
Module: mult_seq_32_bit

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32, product width 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled on rising clk.
REQ-005 SHALL have port a  input  32  multiplicand; sampled only when start is accepted.
REQ-006 SHALL have port b  input  32  multiplier; sampled only when start is accepted.
REQ-007 SHALL have port signed_op  input  1  1 = signed (mult), 0 = unsigned (multu); present only with MULT_SIGNED_EN.
REQ-008 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when hi/lo become valid.
REQ-010 SHALL have port hi  output  32  product bits 63:32.
REQ-011 SHALL have port lo  output  32  product bits 31:0.

Function
REQ-012 SHALL implement a three-state FSM (IDLE, RUN, DONE) with transitions IDLE->RUN on accepted start, RUN->DONE after 32 RUN cycles, and DONE->IDLE or DONE->RUN (if start is accepted).
REQ-013 SHALL accept start only when busy=0 (IDLE or DONE); on accept, latch a, b and signed_op, clear the accumulator, clear the 5-bit step counter and enter RUN.
REQ-014 SHALL ignore start while busy=1, with no effect on operands, counter or outputs.
REQ-015 SHALL, in each RUN cycle, form the partial product as multiplicand bitwise-AND {32{multiplier bit 0}}, add it to the upper 32 bits of the accumulator with a 33-bit carry, shift the 65-bit {carry, accumulator} right by one, and increment the counter.
REQ-016 SHALL leave RUN after the cycle in which the counter wraps from 31 to 0, for exactly 32 RUN cycles.
REQ-017 SHALL provide fixed latency: start accepted at edge 0 gives busy=1 for cycles 1..32 and done=1 in cycle 33 only.
REQ-018 SHALL update hi/lo only on entry to DONE, and SHALL hold them stable until the next DONE.
REQ-019 SHALL keep hi/lo internal accumulation invisible, so that hi/lo show the previous result while busy=1.
REQ-020 SHALL, for a start accepted in the DONE cycle, still pulse done for that cycle and then begin RUN with the new operands.
REQ-021 SHALL handle zero operands through the normal 32-cycle path, with no early termination.

Reset
REQ-022 SHALL, when rst=1 at a rising edge, force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and accumulator=0, regardless of the current state.
REQ-023 SHALL abort any multiply in progress on reset without producing a done pulse, and SHALL give rst priority over a simultaneous start.

Configuration
REQ-024 SHALL use macro MULT_SIGNED_EN; when defined, port signed_op exists, and with signed_op=1 the unit SHALL multiply magnitudes (two's-complement absolute values; 0x80000000 treated as 2^31) and negate the 64-bit result when the operand signs differ, with latency unchanged.
REQ-025 SHALL, when MULT_SIGNED_EN is undefined, omit port signed_op and the sign logic, and SHALL perform unsigned multiplication only.

Verification
REQ-026 SHALL cover: a=3, b=5, start pulse -> busy for 32 cycles, done in cycle 33, hi=0x00000000, lo=0x0000000F.
REQ-027 SHALL cover: unsigned a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-028 SHALL cover (MULT_SIGNED_EN): signed a=0xFFFFFFFF, b=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; signed a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-029 SHALL cover: a=7, b=6 started, then start with a=1, b=1 at cycle 10 -> second start ignored, done at cycle 33, lo=0x0000002A.
REQ-030 SHALL cover: rst asserted in cycle 15 of a multiply -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows.
REQ-031 SHALL cover: back-to-back start in the DONE cycle with a=0, b=9 -> first result shown with done, then second done 33 cycles later with hi=lo=0.

Source files
------------

// File: rtl/mult_seq_32_bit.sv
// Sequential 32x32 shift-add multiplier: 32 RUN cycles, then a one-cycle DONE pulse with hi/lo.
// Optional MULT_SIGNED_EN macro adds port signed_op and signed (sign-magnitude) multiplication.
module mult_seq_32_bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MULT_SIGNED_EN
  input  logic        signed_op,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mcand_q, mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            accept_c, step_c, last_c;
  logic [W:0]      sum_c;
  logic [PW-1:0]   acc_step_c, result_c;
  logic [W-1:0]    mcand_in_c, mplier_in_c;

`ifdef MULT_SIGNED_EN
  logic            neg_q;
  logic            neg_in_c;

  // Signed mode multiplies magnitudes; 0x80000000 negates to itself, read as 2^31.
  always_comb begin
    mcand_in_c  = (signed_op && a[W-1]) ? (~a + W'(1)) : a;
    mplier_in_c = (signed_op && b[W-1]) ? (~b + W'(1)) : b;
    neg_in_c    = signed_op && (a[W-1] ^ b[W-1]);
    result_c    = neg_q ? (~acc_step_c + PW'(1)) : acc_step_c;
  end
`else
  always_comb begin
    mcand_in_c  = a;
    mplier_in_c = b;
    result_c    = acc_step_c;
  end
`endif

  // Next-state, handshake decode and one shift-add step.
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    sum_c      = {1'b0, acc_q[PW-1:W]} + {1'b0, mcand_q & {W{mplier_q[0]}}};
    acc_step_c = {sum_c, acc_q[W-1:1]};
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs; hi/lo change only when entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`ifdef MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
      if (accept_c) begin
        mcand_q  <= mcand_in_c;
        mplier_q <= mplier_in_c;
        acc_q    <= '0;
        cnt_q    <= '0;
`ifdef MULT_SIGNED_EN
        neg_q    <= neg_in_c;
`endif
      end else if (step_c) begin
        acc_q    <= acc_step_c;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
      end
      if (last_c) begin
        hi <= result_c[PW-1:W];
        lo <= result_c[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_32_bit.sv
// Self-checking bench for mult_seq_32_bit: cycle-level behavioural model plus directed literal checks.
// Signed cases are exercised only when MULT_SIGNED_EN is defined.
module tb_mult_seq_32_bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
`ifdef MULT_SIGNED_EN
  logic        sop = 1'b0;
`endif
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_seq_32_bit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef MULT_SIGNED_EN
    .signed_op (sop),
`endif
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] x, input logic [31:0] y, input bit s);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Model: a multiply takes 32 busy cycles, then result appears with a done pulse.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [63:0] m_res  = '0;
  logic [63:0] m_pend = '0;
  int          left   = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : model
    bit old_busy;
    bit s;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_res  = '0;
      left   = 0;
    end else begin
      old_busy = m_busy;
      m_done   = 1'b0;
      if (old_busy) begin
        left--;
        if (left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_res  = m_pend;
        end
      end
      if (!old_busy && start) begin
`ifdef MULT_SIGNED_EN
        s = sop;
`else
        s = 1'b0;
`endif
        m_pend = model_prod(a, b, s);
        m_busy = 1'b1;
        left   = 32;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_hi", hi, m_res[63:32]);
      check("cyc_lo", lo, m_res[31:0]);
    end
  end

  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bcnt);
    n = 0;
    bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic expect_result(input string nm, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] eh, input logic [31:0] el);
    int n, bc;
    start_op(x, y);
    wait_done(n, bc);
    check({nm, "_latency"}, 64'(n), 64'd33);
    check({nm, "_busycycles"}, 64'(bc), 64'd32);
    check({nm, "_hi"}, hi, eh);
    check({nm, "_lo"}, lo, el);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, bc, dcnt;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);

    expect_result("3x5", 32'd3, 32'd5, 32'h0, 32'h0000000F);
    expect_result("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    expect_result("2p16sq", 32'h00010000, 32'h00010000, 32'h00000001, 32'h0);
    expect_result("deadx1", 32'hDEADBEEF, 32'd1, 32'h0, 32'hDEADBEEF);
    expect_result("zero_a", 32'd0, 32'hFFFFFFFF, 32'h0, 32'h0);

    // Start while busy is ignored.
    start_op(32'd7, 32'd6);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 && n == 0) n = i;
      if (i == 10) begin #1; a = 32'd1; b = 32'd1; start = 1'b1; end
      if (i == 11) begin #1; start = 1'b0; end
      if (n != 0) break;
    end
    check("ignore_latency", 64'(n), 64'd33);
    check("ignore_hi", hi, 32'h0);
    check("ignore_lo", lo, 32'h0000002A);

    // Reset in the middle of a multiply aborts it.
    start_op(32'h00001234, 32'h00005678);
    for (int i = 1; i < 15; i++) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);

    // Reset wins over a simultaneous start.
    #1 rst = 1'b1; start = 1'b1; a = 32'd2; b = 32'd2;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", busy, 0);
    @(negedge clk);
    check("rst_prio_busy2", busy, 0);

    // Back-to-back start in the DONE cycle.
    expect_result("b2b_first", 32'h00000100, 32'h00000100, 32'h0, 32'h00010000);
    #1 a = 32'd0; b = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("b2b_busy_next", busy, 1);
    check("b2b_prev_lo", lo, 32'h00010000);
    wait_done(n, bc);
    check("b2b_latency", 64'(n) + 64'd1, 64'd33);
    check("b2b_hi", hi, 32'h0);
    check("b2b_lo", lo, 32'h0);

`ifdef MULT_SIGNED_EN
    sop = 1'b1;
    expect_result("s_m1x2", 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
    expect_result("s_minsq", 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    expect_result("s_5xm3", 32'd5, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1);
    expect_result("s_m3xm3", 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0, 32'h00000009);
    sop = 1'b0;
    expect_result("u_ffx2", 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
